// File: rtl/modn_ctrl_pkg.sv
// rtl/modn_ctrl_pkg.sv - shared state type and constants for the mod-N sequencer
package modn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned N_MIN = 2;

  function automatic logic n_is_legal(input int unsigned n);
    return n >= N_MIN;
  endfunction

endpackage

// File: rtl/modn_seq_ctrl_if.sv
// rtl/modn_seq_ctrl_if.sv - command handshake bundle for modn_seq_ctrl
interface modn_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_n;
  logic [REP_W-1:0] cmd_reps;

  modport master (output cmd_valid, output cmd_n, output cmd_reps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_n, input cmd_reps, output cmd_ready);
endinterface

// File: rtl/modn_cnt_core.sv
// rtl/modn_cnt_core.sv - mod-N counter with registered wrap flag
// o_last marks an enabled edge that leaves N-1, i.e. the edge that closes a period.
module modn_cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_cout,
  output logic             o_wrap,
  output logic             o_last
);

  logic [WIDTH-1:0] r_cout;
  logic             r_wrap;
  logic [WIDTH-1:0] w_n_m1;
  logic [WIDTH-1:0] w_next;

  assign w_n_m1 = i_n - WIDTH'(1);
  assign w_next = (r_cout == w_n_m1) ? '0 : r_cout + WIDTH'(1);

  // wrap is registered against the next count so it lines up with cout==N-1
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cout <= '0;
      r_wrap <= 1'b0;
    end else if (i_en) begin
      r_cout <= w_next;
      r_wrap <= (w_next == w_n_m1);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_cout = r_cout;
  assign o_wrap = r_wrap;
  assign o_last = i_en && (r_cout == w_n_m1);

endmodule

// File: rtl/modn_seq_ctrl.sv
// rtl/modn_seq_ctrl.sv - command-driven sequencer running a mod-N counter for a set number of periods
// Optional pause input is built when MODN_PAUSE_EN is defined.
module modn_seq_ctrl
  import modn_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  modn_seq_ctrl_if.slave   cmd,
  input  logic             i_abort,
`ifdef MODN_PAUSE_EN
  input  logic             i_pause,
`endif
  output logic [WIDTH-1:0] o_cout,
  output logic             o_wrap,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_n;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_load;
  logic             w_hs;
  logic             w_pause;
  logic             w_en;
  logic             w_clr;
  logic             w_last;
  logic             w_final;

`ifdef MODN_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_hs    = cmd.cmd_valid && r_ready;
  assign w_en    = (r_state == RUN) && !w_pause;
  // counter only keeps running across RUN->RUN edges; every other edge zeroes it
  assign w_clr   = (r_state != RUN) || (w_state_nxt != RUN);
  assign w_final = w_last && (r_reps != '0) && (r_rep_cnt == r_reps - REP_W'(1));

  modn_cnt_core #(.WIDTH(WIDTH)) u_cnt_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_n    (r_n),
    .o_cout (o_cout),
    .o_wrap (o_wrap),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (n_is_legal(32'(cmd.cmd_n))) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        // abort wins over a coinciding final wrap
        if (i_abort) begin
          w_state_nxt = IDLE;
        end else if (w_final) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
      r_err   <= w_err_nxt;
    end
  end

  // rep_cnt saturates so an endless run (reps==0) never wraps it back
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n       <= WIDTH'(N_MIN);
      r_reps    <= '0;
      r_rep_cnt <= '0;
    end else if (w_load) begin
      r_n       <= cmd.cmd_n;
      r_reps    <= cmd.cmd_reps;
      r_rep_cnt <= '0;
    end else if (w_last && (r_rep_cnt != '1)) begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_modn_seq_ctrl.sv
// tb/tb_modn_seq_ctrl.sv - scoreboard bench for modn_seq_ctrl
// The pause case is included when MODN_PAUSE_EN is defined.
`timescale 1ns/1ps
module tb_modn_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int REP_W = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic abort = 1'b0;
`ifdef MODN_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [WIDTH-1:0] cout;
  logic wrap, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_wrap  = 0;
  int n_err   = 0;
  int cyc, base_done, base_wrap, base_err;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] sb_e;
  int bad_n[2] = '{1, 0};
  int run_n[3] = '{2, 15, 3};
  int run_r[3] = '{3, 1, 4};

  modn_seq_ctrl_if #(.WIDTH(WIDTH), .REP_W(REP_W)) cmd_if ();

  modn_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .cmd     (cmd_if),
    .i_abort (abort),
`ifdef MODN_PAUSE_EN
    .i_pause (pause),
`endif
    .o_cout  (cout),
    .o_wrap  (wrap),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_cycles(input int n, input int count);
    for (int i = 0; i < count; i++) begin
      int c;
      c = i % n;
      exp_q.push_back({(c == n - 1) ? 1'b1 : 1'b0, WIDTH'(c)});
    end
  endtask

  task automatic send(input int n, input int reps);
    check("ready_before_cmd", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_n     = WIDTH'(n);
    cmd_if.cmd_reps  = REP_W'(reps);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_n     = WIDTH'($urandom);
    cmd_if.cmd_reps  = REP_W'($urandom);
  endtask

  task automatic run_until_done(input int start, input int budget, output int c);
    c = start;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) n_done++;
      if (wrap === 1'b1) n_wrap++;
      if (err === 1'b1) n_err++;
      if (busy === 1'b1) begin
        check("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          check("sb_cout", 32'(cout), 32'(sb_e[WIDTH-1:0]));
          check("sb_wrap", 32'(wrap), 32'(sb_e[WIDTH]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_n     = '0;
    cmd_if.cmd_reps  = '0;

    repeat (2) @(negedge clk);
    check("rst_cout", cout, 0);
    check("rst_wrap", wrap, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", cmd_if.cmd_ready, 1);
    check("idle_busy", busy, 0);

    push_cycles(10, 20);
    base_done = n_done;
    base_wrap = n_wrap;
    send(10, 2);
    run_until_done(1, 60, cyc);
    check("t2_done_cycle", cyc, 21);
    check("t2_done_busy", busy, 0);
    check("t2_done_cout", cout, 0);
    check("t2_done_ready", cmd_if.cmd_ready, 0);
    @(negedge clk);
    check("t2_ready_after", cmd_if.cmd_ready, 1);
    check("t2_done_width", done, 0);
    check("t2_wraps", n_wrap - base_wrap, 2);
    check("t2_dones", n_done - base_done, 1);
    check("t2_sb_empty", exp_q.size(), 0);

    for (int k = 0; k < 2; k++) begin
      base_err = n_err;
      send(bad_n[k], 3);
      check("t3_err", err, 1);
      check("t3_busy", busy, 0);
      check("t3_ready", cmd_if.cmd_ready, 1);
      @(negedge clk);
      check("t3_err_width", err, 0);
      check("t3_still_idle", busy, 0);
      check("t3_err_count", n_err - base_err, 1);
    end

    for (int k = 0; k < 3; k++) begin
      push_cycles(run_n[k], run_n[k] * run_r[k]);
      send(run_n[k], run_r[k]);
      run_until_done(1, 200, cyc);
      check("run_done_cycle", cyc, run_n[k] * run_r[k] + 1);
      @(negedge clk);
      check("run_sb_empty", exp_q.size(), 0);
    end

    push_cycles(5, 23);
    base_done = n_done;
    base_wrap = n_wrap;
    send(5, 0);
    repeat (22) @(negedge clk);
    check("t4_cout_at_abort", cout, 2);
    check("t4_busy_at_abort", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_cout_after", cout, 0);
    check("t4_busy_after", busy, 0);
    check("t4_ready_after", cmd_if.cmd_ready, 1);
    check("t4_done_after", done, 0);
    @(negedge clk);
    check("t4_wraps", n_wrap - base_wrap, 4);
    check("t4_dones", n_done - base_done, 0);
    check("t4_sb_empty", exp_q.size(), 0);

    push_cycles(3, 3);
    base_done = n_done;
    send(3, 1);
    repeat (2) @(negedge clk);
    check("t5_cout_last", cout, 2);
    check("t5_wrap_last", wrap, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_done_after", done, 0);
    check("t5_busy_after", busy, 0);
    check("t5_ready_after", cmd_if.cmd_ready, 1);
    check("t5_cout_after", cout, 0);
    @(negedge clk);
    check("t5_dones", n_done - base_done, 0);
    check("t5_sb_empty", exp_q.size(), 0);

    push_cycles(7, 1);
    send(7, 3);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_cout", cout, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", cmd_if.cmd_ready, 1);
    check("t5_rst_done", done, 0);
    check("t5_rst_wrap", wrap, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_ready", cmd_if.cmd_ready, 1);
    check("t5_post_busy", busy, 0);
    check("t5_post_done", done, 0);
    check("t5_post_sb_empty", exp_q.size(), 0);

`ifdef MODN_PAUSE_EN
    exp_q.push_back({1'b0, WIDTH'(0)});
    exp_q.push_back({1'b0, WIDTH'(1)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, WIDTH'(2)});
    exp_q.push_back({1'b1, WIDTH'(3)});
    send(4, 1);
    repeat (2) @(negedge clk);
    check("t6_cout_pre", cout, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_hold_cout", cout, 2);
      check("t6_hold_wrap", wrap, 0);
      check("t6_hold_busy", busy, 1);
    end
    pause = 1'b0;
    run_until_done(6, 40, cyc);
    check("t6_done_cycle", cyc, 8);
    @(negedge clk);
    check("t6_sb_empty", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
